// File: rtl/gpr_bank_read_arbiter_pkg.sv
// rtl/gpr_bank_read_arbiter_pkg.sv - shared GPR bank geometry helpers
// Purpose: default parameters plus the bank-select and bank-address helpers used
//          by the read arbiter and by any other block wiring the banked GPR file.
// Ports:   none (package).
package gpr_bank_read_arbiter_pkg;

    localparam int DEF_NUM_REQS  = 4;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_NR_BITS   = 6;
    localparam int DEF_WIS_W     = 2;
    localparam int DEF_DATAW     = 64;
    localparam int DEF_TAG_W     = 2;

    // Index width that never collapses to zero bits (NUM_REQS=1 still needs a wire).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bank_sel_width(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int bank_addr_width(input int nr_bits, input int wis_w, input int num_banks);
        return wis_w + nr_bits - $clog2(num_banks);
    endfunction

    // Bank is the low rid bits; NUM_BANKS is a power of two so a mask suffices.
    function automatic logic [31:0] gpr_bank_sel(input logic [31:0] rid, input int num_banks);
        return rid & 32'(num_banks - 1);
    endfunction

    // Row within a bank: {wis, rid >> BANK_SEL_W}.
    function automatic logic [31:0] gpr_bank_addr(input logic [31:0] wis, input logic [31:0] rid,
                                                  input int nr_bits, input int num_banks);
        int sel_w;
        sel_w = $clog2(num_banks);
        return (wis << (nr_bits - sel_w)) | (rid >> sel_w);
    endfunction

endpackage

// File: rtl/gpr_bank_read_arbiter_rr.sv
// rtl/gpr_bank_read_arbiter_rr.sv - per-bank round-robin arbiter
// Purpose: picks the first requesting index at or after the rotating pointer and
//          advances the pointer past the winner.
// Ports:   clk, reset (sync, active-high); req in NUM_REQS; grant out one-hot;
//          grant_idx out winner index; grant_valid out any grant this cycle.
module gpr_bank_rr_arbiter
    import gpr_bank_read_arbiter_pkg::*;
#(
    parameter int NUM_REQS = DEF_NUM_REQS,
    parameter int IDX_W    = idx_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(ptr) + k) % NUM_REQS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gpr_bank_read_arbiter.sv
// rtl/gpr_bank_read_arbiter.sv - banked GPR read-port arbiter for one issue slice
// Purpose: routes operand-collector read requests to GPR banks, one grant per bank
//          per cycle, and returns the row plus tag to the winner two cycles later.
// Ports:   clk, reset (sync, active-high)
//          req_valid/req_wis/req_rid/req_tag in, req_ready out (combinational)
//          bank_rd_addr/bank_rd_en out (registered), bank_rd_data in
//          rsp_valid/rsp_data/rsp_tag out (registered), perf_conflicts out
module gpr_bank_read_arbiter
    import gpr_bank_read_arbiter_pkg::*;
#(
    parameter int NUM_REQS   = DEF_NUM_REQS,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int NR_BITS    = DEF_NR_BITS,
    parameter int WIS_W      = DEF_WIS_W,
    parameter int DATAW      = DEF_DATAW,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int WIS_WP     = (WIS_W > 0) ? WIS_W : 1,
    parameter int BANK_ADDRW = bank_addr_width(NR_BITS, WIS_W, NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*WIS_WP-1:0]    req_wis,
    input  logic [NUM_REQS*NR_BITS-1:0]   req_rid,
    input  logic [NUM_REQS*TAG_W-1:0]     req_tag,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic [NUM_BANKS*BANK_ADDRW-1:0] bank_rd_addr,
    output logic [NUM_BANKS-1:0]          bank_rd_en,
    input  logic [NUM_BANKS*DATAW-1:0]    bank_rd_data,
    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [NUM_REQS*DATAW-1:0]     rsp_data,
    output logic [NUM_REQS*TAG_W-1:0]     rsp_tag,
    output logic [31:0]                   perf_conflicts
);

    localparam int IDX_W = idx_width(NUM_REQS);

    logic [NUM_BANKS-1:0][NUM_REQS-1:0]  cand;
    logic [NUM_BANKS-1:0][NUM_REQS-1:0]  grant;
    logic [NUM_BANKS-1:0][IDX_W-1:0]     grant_idx;
    logic [NUM_BANKS-1:0]                grant_any;
    logic [NUM_REQS-1:0][BANK_ADDRW-1:0] req_addr;

    logic [NUM_BANKS-1:0]                s1_valid;
    logic [NUM_BANKS-1:0][IDX_W-1:0]     s1_idx;
    logic [NUM_BANKS-1:0][TAG_W-1:0]     s1_tag;

    logic [NUM_REQS-1:0]                 nxt_valid;
    logic [NUM_REQS*DATAW-1:0]           nxt_data;
    logic [NUM_REQS*TAG_W-1:0]           nxt_tag;

    // Candidates are masked by reset so nothing is accepted (or pointers moved)
    // while the block is held in reset.
    always_comb begin
        cand     = '0;
        req_addr = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            req_addr[r] = BANK_ADDRW'(gpr_bank_addr(
                (WIS_W > 0) ? 32'(req_wis[r*WIS_WP +: WIS_WP]) : 32'd0,
                32'(req_rid[r*NR_BITS +: NR_BITS]), NR_BITS, NUM_BANKS));
            for (int b = 0; b < NUM_BANKS; b++) begin
                cand[b][r] = req_valid[r] && !reset &&
                             (gpr_bank_sel(32'(req_rid[r*NR_BITS +: NR_BITS]), NUM_BANKS) == 32'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        gpr_bank_rr_arbiter #(
            .NUM_REQS (NUM_REQS),
            .IDX_W    (IDX_W)
        ) u_arb (
            .clk         (clk),
            .reset       (reset),
            .req         (cand[b]),
            .grant       (grant[b]),
            .grant_idx   (grant_idx[b]),
            .grant_valid (grant_any[b])
        );
    end

    // A requester targets exactly one bank, so OR-ing the per-bank grants is safe.
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_ready = req_ready | grant[b];
        end
    end

    // Stage 1: registered bank read address/enable, winner id and tag ride along.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= '0;
            bank_rd_addr <= '0;
        end else begin
            s1_valid <= grant_any;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (grant_any[b]) begin
                    s1_idx[b] <= grant_idx[b];
                    s1_tag[b] <= req_tag[int'(grant_idx[b])*TAG_W +: TAG_W];
                    bank_rd_addr[b*BANK_ADDRW +: BANK_ADDRW] <= req_addr[grant_idx[b]];
                end
            end
        end
    end

    assign bank_rd_en = s1_valid;

    // Stage 2: steer each active bank's data back to its winner. A requester has at
    // most one request in flight per cycle, so no two banks target the same slot.
    always_comb begin
        nxt_valid = '0;
        nxt_data  = rsp_data;
        nxt_tag   = rsp_tag;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1_valid[b]) begin
                nxt_valid[s1_idx[b]]                         = 1'b1;
                nxt_data[int'(s1_idx[b])*DATAW +: DATAW]     = bank_rd_data[b*DATAW +: DATAW];
                nxt_tag[int'(s1_idx[b])*TAG_W +: TAG_W]      = s1_tag[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
        end else begin
            rsp_valid <= nxt_valid;
        end
        rsp_data <= nxt_data;
        rsp_tag  <= nxt_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflicts <= '0;
        end else if (|(req_valid & ~req_ready)) begin
            perf_conflicts <= perf_conflicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_gpr_bank_read_arbiter.sv
// tb/tb_gpr_bank_read_arbiter.sv - self-checking bench for gpr_bank_read_arbiter
module tb_gpr_bank_read_arbiter;

    localparam int NR  = 4;
    localparam int NB  = 4;
    localparam int NRB = 6;
    localparam int WW  = 2;
    localparam int DW  = 32;
    localparam int TW  = 2;
    localparam int AW  = 6;
    localparam int AW1 = 8;

    logic clk;
    logic reset;

    logic [NR-1:0]      req_valid;
    logic [NR*WW-1:0]   req_wis;
    logic [NR*NRB-1:0]  req_rid;
    logic [NR*TW-1:0]   req_tag;
    logic [NR-1:0]      req_ready;
    logic [NB*AW-1:0]   bank_rd_addr;
    logic [NB-1:0]      bank_rd_en;
    logic [NB*DW-1:0]   bank_rd_data;
    logic [NR-1:0]      rsp_valid;
    logic [NR*DW-1:0]   rsp_data;
    logic [NR*TW-1:0]   rsp_tag;
    logic [31:0]        perf;

    logic [NR-1:0]      req_valid1;
    logic [NR*WW-1:0]   req_wis1;
    logic [NR*NRB-1:0]  req_rid1;
    logic [NR*TW-1:0]   req_tag1;
    logic [NR-1:0]      req_ready1;
    logic [AW1-1:0]     bank_rd_addr1;
    logic [0:0]         bank_rd_en1;
    logic [DW-1:0]      bank_rd_data1;
    logic [NR-1:0]      rsp_valid1;
    logic [NR*DW-1:0]   rsp_data1;
    logic [NR*TW-1:0]   rsp_tag1;
    logic [31:0]        perf1;

    int errors = 0;
    int checks = 0;

    gpr_bank_read_arbiter #(
        .NUM_REQS(NR), .NUM_BANKS(NB), .NR_BITS(NRB), .WIS_W(WW), .DATAW(DW), .TAG_W(TW)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wis(req_wis), .req_rid(req_rid), .req_tag(req_tag),
        .req_ready(req_ready),
        .bank_rd_addr(bank_rd_addr), .bank_rd_en(bank_rd_en), .bank_rd_data(bank_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .perf_conflicts(perf)
    );

    gpr_bank_read_arbiter #(
        .NUM_REQS(NR), .NUM_BANKS(1), .NR_BITS(NRB), .WIS_W(WW), .DATAW(DW), .TAG_W(TW)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_wis(req_wis1), .req_rid(req_rid1), .req_tag(req_tag1),
        .req_ready(req_ready1),
        .bank_rd_addr(bank_rd_addr1), .bank_rd_en(bank_rd_en1), .bank_rd_data(bank_rd_data1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1),
        .perf_conflicts(perf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents are a recognisable function of bank and row.
    function automatic logic [31:0] ram(input int b, input int a);
        return 32'hA5A5_0000 | (32'(b) << 12) | 32'(a);
    endfunction

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_rd_data[b*DW +: DW] = ram(b, int'(bank_rd_addr[b*AW +: AW]));
        end
        bank_rd_data1 = ram(0, int'(bank_rd_addr1));
    end

    // Requests the bench is presenting (held until granted).
    bit v[NR];
    int wis[NR], rid[NR], tag[NR];

    // Reference model state.
    int          ptr[NB];
    int          perf_m;
    bit          s1v[NB];
    int          s1r[NB], s1t[NB], s1a[NB];
    bit          rv[NR];
    logic [31:0] rdat[NR];
    int          rtg[NR];

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            req_valid[r]           = v[r];
            req_wis[r*WW +: WW]    = 2'(wis[r]);
            req_rid[r*NRB +: NRB]  = 6'(rid[r]);
            req_tag[r*TW +: TW]    = 2'(tag[r]);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            ptr[b] = 0; s1v[b] = 0;
        end
        for (int r = 0; r < NR; r++) rv[r] = 0;
        perf_m = 0;
    endtask

    task automatic clear_reqs();
        for (int r = 0; r < NR; r++) begin
            v[r] = 0; wis[r] = 0; rid[r] = 1; tag[r] = 0;
        end
    endtask

    // One cycle: drive, compare against the model, clock, advance the model.
    task automatic step();
        int win[NB];
        bit g[NR];
        bit lose;
        drive();
        #1;
        for (int r = 0; r < NR; r++) g[r] = 0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            if (!reset) begin
                for (int k = 0; k < NR; k++) begin
                    int r;
                    r = (ptr[b] + k) % NR;
                    if (win[b] < 0 && v[r] && (rid[r] % NB) == b) win[b] = r;
                end
            end
            if (win[b] >= 0) g[win[b]] = 1;
        end
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("ready%0d", r), 64'(req_ready[r]), 64'(g[r]));
            chk($sformatf("rsp_valid%0d", r), 64'(rsp_valid[r]), 64'(rv[r]));
            if (rv[r]) begin
                chk($sformatf("rsp_data%0d", r), 64'(rsp_data[r*DW +: DW]), 64'(rdat[r]));
                chk($sformatf("rsp_tag%0d", r), 64'(rsp_tag[r*TW +: TW]), 64'(rtg[r]));
            end
        end
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("rd_en%0d", b), 64'(bank_rd_en[b]), 64'(s1v[b]));
            if (s1v[b]) chk($sformatf("rd_addr%0d", b), 64'(bank_rd_addr[b*AW +: AW]), 64'(s1a[b]));
        end
        chk("perf", 64'(perf), 64'(perf_m));
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            lose = 0;
            for (int r = 0; r < NR; r++) begin
                rv[r] = 0;
                if (v[r] && !g[r]) lose = 1;
            end
            for (int b = 0; b < NB; b++) begin
                if (s1v[b]) begin
                    rv[s1r[b]]   = 1;
                    rdat[s1r[b]] = ram(b, s1a[b]);
                    rtg[s1r[b]]  = s1t[b];
                end
            end
            for (int b = 0; b < NB; b++) begin
                s1v[b] = (win[b] >= 0);
                if (win[b] >= 0) begin
                    s1r[b] = win[b];
                    s1t[b] = tag[win[b]];
                    s1a[b] = wis[win[b]] * (64 / NB) + rid[win[b]] / NB;
                    ptr[b] = (win[b] + 1) % NR;
                end
            end
            if (lose) perf_m = perf_m + 1;
            for (int r = 0; r < NR; r++) if (g[r]) v[r] = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_reqs();
        drive();
        req_valid1 = '0; req_wis1 = '0; req_rid1 = '0; req_tag1 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Four requesters on four distinct banks: all accepted together.
        for (int r = 0; r < NR; r++) begin
            v[r] = 1; rid[r] = r + 1; tag[r] = r; wis[r] = 0;
        end
        drive(); #1;
        chk("t1_ready", 64'(req_ready), 64'h0F);
        step();
        chk("t1_rd_en", 64'(bank_rd_en), 64'h0F);
        step();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h0F);
        step();

        // All four on bank 1, held: serialized r0..r3, in-order responses.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            v[r] = 1; rid[r] = 5; tag[r] = 3 - r; wis[r] = 1;
        end
        for (int i = 0; i < 6; i++) begin
            drive(); #1;
            if (i < 4) chk("t2_ready", 64'(req_ready), 64'(1 << i));
            if (i >= 2) begin
                chk("t2_rsp_valid", 64'(rsp_valid), 64'(1 << (i - 2)));
                chk("t2_rsp_tag", 64'(rsp_tag[(i-2)*TW +: TW]), 64'(3 - (i - 2)));
            end
            step();
        end
        chk("t2_perf", 64'(perf), 64'd3);

        // Pointer wrap: r3 wins bank 2, then r0 beats r3.
        do_reset();
        v[3] = 1; rid[3] = 6; tag[3] = 2;
        drive(); #1;
        chk("t3_first", 64'(req_ready), 64'h8);
        step();
        v[0] = 1; rid[0] = 2; v[3] = 1; rid[3] = 6;
        drive(); #1;
        chk("t3_wrap", 64'(req_ready), 64'h1);
        step();
        step();
        step();
        step();

        // Address composition: wis=2, rid=9 -> bank 1, row {2,2}.
        do_reset();
        v[1] = 1; wis[1] = 2; rid[1] = 9; tag[1] = 1;
        step();
        chk("t4_rd_en", 64'(bank_rd_en), 64'h2);
        chk("t4_rd_addr", 64'(bank_rd_addr[1*AW +: AW]), 64'h22);
        step();
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t4_rsp_data", 64'(rsp_data[1*DW +: DW]), 64'hA5A5_1022);
        step();

        // Reset right after an accept kills the in-flight read and the pointers.
        do_reset();
        v[0] = 1; rid[0] = 1; tag[0] = 3;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(); #1;
            chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
            step();
        end
        v[0] = 1; rid[0] = 1; v[1] = 1; rid[1] = 5;
        drive(); #1;
        chk("t5_ptr_reset", 64'(req_ready), 64'h1);
        step();
        step();
        step();
        step();

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!v[r] && ($urandom % 3) != 0) begin
                    v[r]   = 1;
                    wis[r] = int'($urandom % 4);
                    rid[r] = int'($urandom_range(1, 63));
                    tag[r] = int'($urandom % 4);
                end
            end
            reset = (($urandom % 60) == 0);
            step();
        end
        reset = 1'b0;

        // Single-bank build: two requests serialize, each with 2-cycle latency.
        do_reset();
        req_valid1 = 4'b0011;
        req_rid1   = {6'd0, 6'd0, 6'd7, 6'd4};
        req_tag1   = {2'd0, 2'd0, 2'd2, 2'd1};
        #1;
        chk("t6_ready_n", 64'(req_ready1), 64'h1);
        step();
        req_valid1 = 4'b0010;
        #1;
        chk("t6_ready_n1", 64'(req_ready1), 64'h2);
        chk("t6_rd_en", 64'(bank_rd_en1), 64'h1);
        chk("t6_rd_addr0", 64'(bank_rd_addr1), 64'h04);
        step();
        req_valid1 = 4'b0000;
        #1;
        chk("t6_rsp0_valid", 64'(rsp_valid1), 64'h1);
        chk("t6_rsp0_tag", 64'(rsp_tag1[1:0]), 64'd1);
        chk("t6_rsp0_data", 64'(rsp_data1[31:0]), 64'hA5A5_0004);
        chk("t6_rd_addr1", 64'(bank_rd_addr1), 64'h07);
        step();
        chk("t6_rsp1_valid", 64'(rsp_valid1), 64'h2);
        chk("t6_rsp1_tag", 64'(rsp_tag1[3:2]), 64'd2);
        chk("t6_rsp1_data", 64'(rsp_data1[63:32]), 64'hA5A5_0007);
        step();
        chk("t6_rsp_idle", 64'(rsp_valid1), 64'h0);
        chk("t6_perf", 64'(perf1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
